// File: rtl/operand_fetch.sv
// Operand fetch stage: tracks per-register busy bits, stalls on RAW/WAW hazards and issues operands.
// Optional writeback bypass is compiled in when OPFETCH_BYPASS_EN is defined.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_wr,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and out_* hold steady while out_valid is 1 and out_ready is 0.

  logic [NUM_REGS-1:0] busyQ;
  logic [NUM_REGS-1:0] busyD;
  logic                outValidQ;
  logic [3:0]          outOpQ;
  logic [ADDR_W-1:0]   outRdQ;
  logic                outWrQ;
  logic [DATA_W-1:0]   outAQ;
  logic [DATA_W-1:0]   outBQ;

  logic              src1Busy;
  logic              src2Busy;
  logic              rdBusy;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] operandB;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

`ifdef OPFETCH_BYPASS_EN
  // A source being written back this cycle is taken from the writeback bus instead of waiting.
  logic bypass1;
  logic bypass2;
  assign bypass1  = wb_valid && (wb_addr == in_rs1);
  assign bypass2  = wb_valid && (wb_addr == in_rs2);
  assign src1Busy = busyQ[in_rs1] && !bypass1;
  assign src2Busy = busyQ[in_rs2] && !bypass2;
  assign operandA = bypass1 ? wb_data : rf_rdata1;
  assign operandB = bypass2 ? wb_data : rf_rdata2;
`else
  logic [DATA_W-1:0] unusedWbData;
  assign unusedWbData = wb_data;
  assign src1Busy = busyQ[in_rs1];
  assign src2Busy = busyQ[in_rs2];
  assign operandA = rf_rdata1;
  assign operandB = rf_rdata2;
`endif

  assign rdBusy   = in_wr && busyQ[in_rd];
  assign hazard   = in_valid && (src1Busy || src2Busy || rdBusy);
  assign in_ready = rst_n && !hazard && (!outValidQ || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is applied after clear so a same-edge issue to the written-back register stays busy.
  always_comb begin
    busyD = busyQ;
    if (wb_valid) busyD[wb_addr] = 1'b0;
    if (accept && in_wr) busyD[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busyQ <= '0;
    else        busyQ <= busyD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      outOpQ    <= '0;
      outRdQ    <= '0;
      outWrQ    <= 1'b0;
      outAQ     <= '0;
      outBQ     <= '0;
    end else if (accept) begin
      outValidQ <= 1'b1;
      outOpQ    <= in_op;
      outRdQ    <= in_rd;
      outWrQ    <= in_wr;
      outAQ     <= operandA;
      outBQ     <= operandB;
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  assign out_valid = outValidQ;
  assign out_op    = outOpQ;
  assign out_rd    = outRdQ;
  assign out_wr    = outWrQ;
  assign out_a     = outAQ;
  assign out_b     = outBQ;
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; 2**ADDR_W registers are tracked.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: upstream instruction handshake.
REQ-006 SHALL have ports in_op input 4 opcode; in_rd, in_rs1, in_rs2 input ADDR_W each: dest/source addresses; in_wr input 1: instruction writes rd.
REQ-007 SHALL have ports rf_raddr1, rf_raddr2 output ADDR_W, rf_rdata1, rf_rdata2 input DATA_W: register file read ports, read data combinational.
REQ-008 SHALL have ports wb_valid input 1, wb_addr input ADDR_W, wb_data input DATA_W: writeback completion notice.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: downstream execute handshake.
REQ-010 SHALL have ports out_op output 4, out_rd output ADDR_W, out_wr output 1, out_a, out_b output DATA_W: issued instruction and operands.

Function
REQ-011 SHALL drive rf_raddr1 = in_rs1 and rf_raddr2 = in_rs2 combinationally at all times.
REQ-012 SHALL hold a busy bit per register; busy[r]=1 means a write to r is issued but not yet written back.
REQ-013 SHALL flag a hazard when in_valid and any of busy[in_rs1], busy[in_rs2], or (in_wr and busy[in_rd]) is 1.
REQ-014 SHALL drive in_ready = rst_n and not hazard and (not out_valid or out_ready), combinationally.
REQ-015 SHALL, on an accept edge (in_valid and in_ready), load out_op/rd/wr from inputs and out_a/out_b from rf_rdata1/2, set out_valid=1; latency 1 cycle.
REQ-016 SHALL, on accept with in_wr=1, set busy[in_rd] at the same edge.
REQ-017 SHALL, on wb_valid, clear busy[wb_addr] at that edge; if the same edge also sets that address, set wins.
REQ-018 SHALL clear out_valid on out_valid and out_ready with no accept; SHALL hold all out_* stable while out_valid and not out_ready.
REQ-019 SHALL support back-to-back issue: out_ready=1 and an accept in one cycle replaces the output register with no bubble.
REQ-020 SHALL, when in_rs1 equals in_rs2, treat both as one source for hazard purposes (no double-counting, same result).
REQ-021 SHALL evaluate the hazard against registered busy bits; a register cleared by writeback at edge N unblocks from cycle N+1 (without REQ-027).

Reset
REQ-022 SHALL, while rst_n=0, force out_valid=0, all busy bits=0, out_op/rd/wr/a/b=0, in_ready=0.
REQ-023 SHALL, on reset mid-operation, discard the held instruction and all pending busy state; no writeback is expected afterwards.
REQ-024 SHALL accept the first instruction no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile a writeback-bypass path only when macro OPFETCH_BYPASS_EN is defined.
REQ-026 SHALL, without OPFETCH_BYPASS_EN, behave exactly per REQ-011..REQ-021.
REQ-027 SHALL, with OPFETCH_BYPASS_EN, ignore busy for any source equal to wb_addr while wb_valid, and capture wb_data instead of rf_rdata for that operand on accept; rd (WAW) check is unaffected.

Verification
REQ-028 SHALL cover: rf r1=15, r3=10; issue rs1=1, rs2=3, rd=5, in_wr=1, out_ready=1 -> next cycle out_valid=1, out_a=15, out_b=10, busy[5]=1.
REQ-029 SHALL cover: busy[5]=1; issue rs1=5 -> in_ready=0 until wb_valid, wb_addr=5; accepted cycle after (no macro) or same cycle with out_a=wb_data (macro).
REQ-030 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 with new in_valid -> replaced with no bubble.
REQ-031 SHALL cover: busy[7]=1, issue in_wr=1 rd=7, sources clear -> stalled (WAW) until wb_addr=7 written back.
REQ-032 SHALL cover: rst_n pulsed low while out_valid=1 and busy[5]=1 -> out_valid=0, busy all 0, all out_* 0 immediately.
REQ-033 SHALL cover: accept with in_wr=1 rd=9 coincident with wb_valid wb_addr=9 on an idle register -> busy[9]=1 after the edge.
